// File: rtl/dpsm_pkg.sv
// dpsm_pkg: shared state encoding and default beat parameters for the DPSM beat path
package dpsm_pkg;
    localparam int DPSM_L        = 6;
    localparam int DPSM_MIN_BEAT = 16;
    localparam int DPSM_MAX_BEAT = 1023;
    typedef enum logic [2:0] {
        IDLE,
        INIT_CLR,
        CALIB,
        CAL_QRS,
        RUN,
        RUN_QRS,
        CAPTURE,
        HOLD
    } dpsm_state_e;
endpackage

// File: rtl/dpsm_beat_ctrl.sv
// dpsm_beat_ctrl: sequences calibration and per-beat ratio capture around the dpsm_cv datapath
module dpsm_beat_ctrl
    import dpsm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int L          = DPSM_L,
    parameter int MIN_BEAT   = DPSM_MIN_BEAT,
    parameter int MAX_BEAT   = DPSM_MAX_BEAT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_vqx,
    input  logic [DATA_WIDTH-1:0] s_vqy,
    input  logic                  r_peak,
    output logic                  cv_en,
    output logic                  cv_qrs,
    output logic                  cv1_flag,
    output logic [DATA_WIDTH-1:0] cv_vqx,
    output logic [DATA_WIDTH-1:0] cv_vqy,
    input  logic [DATA_WIDTH-1:0] cv_y,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_cv,
    output logic [DATA_WIDTH-1:0] m_beat_len,
    output logic                  busy,
    output logic                  calib_done,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] drop_cnt
);
    localparam logic [DATA_WIDTH-1:0] L_Q      = DATA_WIDTH'(L);
    localparam logic [DATA_WIDTH-1:0] MIN_Q    = DATA_WIDTH'(MIN_BEAT);
    localparam logic [DATA_WIDTH-1:0] MAX_M1_Q = DATA_WIDTH'(MAX_BEAT - 1);

    dpsm_state_e           state, state_n;
    logic [DATA_WIDTH-1:0] beat_len;
    logic                  pend, fwd, stop_l, pend_clr;
    logic                  in_phase, take, keep, hit_max, stop_any;

    // A boundary is serviced only once the last forwarded sample has left,
    // so the cv_qrs pulse never shares a cycle with a sample on cv_en.
    assign in_phase = (state == CALIB) || (state == RUN);
    assign take     = s_valid && s_ready;
    assign keep     = take && (s_vqx <= L_Q) && (s_vqy <= L_Q);
    assign hit_max  = keep && (beat_len == MAX_M1_Q);
    assign stop_any = stop || stop_l;
    assign m_valid  = state == HOLD;
    assign busy     = state != IDLE;

    // state register
    always_ff @(posedge clk)
        state <= rstn ? IDLE : state_n;

    // next state, sample acceptance and datapath control strobes
    always_comb begin
        state_n  = state;
        s_ready  = 1'b0;
        cv_en    = fwd;
        cv_qrs   = 1'b0;
        cv1_flag = 1'b0;
        pend_clr = 1'b0;
        case (state)
            IDLE:     state_n = start ? INIT_CLR : IDLE;
            INIT_CLR: begin
                cv_en   = 1'b1;
                cv_qrs  = 1'b1;
                state_n = CALIB;
            end
            CALIB, RUN: begin
                s_ready = !pend;
                if (pend && !fwd) begin
                    pend_clr = 1'b1;
                    if (beat_len < MIN_Q) begin
                        cv_en  = 1'b1;
                        cv_qrs = 1'b1;
                    end else
                        state_n = (state == CALIB) ? CAL_QRS : RUN_QRS;
                end else if (!pend && stop_any)
                    state_n = IDLE;
            end
            CAL_QRS: begin
                cv_en    = 1'b1;
                cv_qrs   = 1'b1;
                cv1_flag = 1'b1;
                state_n  = RUN;
            end
            RUN_QRS: begin
                cv_en   = 1'b1;
                cv_qrs  = 1'b1;
                state_n = CAPTURE;
            end
            CAPTURE:  state_n = HOLD;
            HOLD:     state_n = m_ready ? (stop_any ? IDLE : RUN) : HOLD;
            default:  state_n = IDLE;
        endcase
    end

    // beat bookkeeping, sample forwarding, result capture and sticky status
    always_ff @(posedge clk) begin
        if (rstn) begin
            beat_len   <= '0;
            pend       <= 1'b0;
            fwd        <= 1'b0;
            stop_l     <= 1'b0;
            cv_vqx     <= '0;
            cv_vqy     <= '0;
            drop_cnt   <= '0;
            m_cv       <= '0;
            m_beat_len <= '0;
            calib_done <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            fwd      <= keep;
            beat_len <= cv_qrs ? '0 : keep ? beat_len + 1'b1 : beat_len;
            pend     <= (state_n == IDLE || pend_clr) ? 1'b0 : pend || (in_phase && r_peak) || hit_max;
            stop_l   <= (state == IDLE) ? 1'b0 : stop_l || stop;
            if (keep) begin
                cv_vqx <= s_vqx;
                cv_vqy <= s_vqy;
            end
            if (take && !keep && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
            if (state == RUN_QRS)
                m_beat_len <= beat_len;
            if (state == CAPTURE)
                m_cv <= cv_y;
            if (hit_max)
                timeout <= 1'b1;
            else if (state == IDLE && start)
                timeout <= 1'b0;
            if (state == CAL_QRS)
                calib_done <= 1'b1;
            else if (state == IDLE && start)
                calib_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dpsm_beat_ctrl.sv
// tb_dpsm_beat_ctrl: randomized scoreboard bench for the DPSM beat controller
module tb_dpsm_beat_ctrl;
    localparam int DW   = 16;
    localparam int LL   = 6;
    localparam int MINB = 16;
    localparam int MAXB = 32;

    typedef struct packed {logic [DW-1:0] x; logic [DW-1:0] y;} smp_t;
    typedef struct packed {logic [DW-1:0] cv; logic [DW-1:0] len;} res_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0, stop = 1'b0, s_valid = 1'b0, r_peak = 1'b0, m_ready = 1'b0;
    logic [DW-1:0] s_vqx = '0, s_vqy = '0, cv_y = '0;
    logic          s_ready, cv_en, cv_qrs, cv1_flag, m_valid, busy, calib_done, timeout;
    logic [DW-1:0] cv_vqx, cv_vqy, m_cv, m_beat_len, drop_cnt;

    int checks = 0;
    int errors = 0;
    bit rdy_auto = 1'b0;

    smp_t fwd_q[$];
    bit   qrs_q[$];
    res_t res_q[$];

    bit            calib_ph;
    int            cur_len;
    logic [DW-1:0] cur_cvy;
    logic [DW-1:0] exp_drop;
    bit            exp_to, exp_cal;

    dpsm_beat_ctrl #(.DATA_WIDTH(DW), .L(LL), .MIN_BEAT(MINB), .MAX_BEAT(MAXB)) dut (
        .clk(clk), .rstn(rstn), .start(start), .stop(stop),
        .s_valid(s_valid), .s_ready(s_ready), .s_vqx(s_vqx), .s_vqy(s_vqy),
        .r_peak(r_peak), .cv_en(cv_en), .cv_qrs(cv_qrs), .cv1_flag(cv1_flag),
        .cv_vqx(cv_vqx), .cv_vqy(cv_vqy), .cv_y(cv_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_cv(m_cv), .m_beat_len(m_beat_len),
        .busy(busy), .calib_done(calib_done), .timeout(timeout), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output present, required none expected", name);
    endtask

    // Reference rule for a closed beat: short beats only clear, the first long
    // beat of a session calibrates, later long beats yield a result.
    function automatic void boundary();
        if (cur_len < MINB)
            qrs_q.push_back(1'b0);
        else if (calib_ph) begin
            qrs_q.push_back(1'b1);
            calib_ph = 1'b0;
            exp_cal  = 1'b1;
        end else begin
            qrs_q.push_back(1'b0);
            res_q.push_back('{cur_cvy, DW'(cur_len)});
        end
        cur_len = 0;
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_auto)
            m_ready = ($urandom_range(0, 2) != 0);
    end

    // monitor: compares every DUT presentation against the scoreboard queues
    initial begin
        bit            hold;
        logic [DW-1:0] pcv, plen;
        smp_t          es;
        res_t          er;
        hold = 1'b0;
        pcv  = '0;
        plen = '0;
        forever begin
            @(negedge clk);
            if (rstn)
                hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_cv", m_cv, pcv);
                    chk("hold_len", m_beat_len, plen);
                end
                if (cv_qrs) begin
                    chk("qrs_en", cv_en, 1);
                    if (qrs_q.size() == 0)
                        miss("qrs_unexpected");
                    else
                        chk("qrs_cv1_flag", cv1_flag, qrs_q.pop_front());
                end else if (cv_en) begin
                    if (fwd_q.size() == 0)
                        miss("fwd_unexpected");
                    else begin
                        es = fwd_q.pop_front();
                        chk("fwd_vqx", cv_vqx, es.x);
                        chk("fwd_vqy", cv_vqy, es.y);
                    end
                end
                if (m_valid && m_ready) begin
                    if (res_q.size() == 0)
                        miss("result_unexpected");
                    else begin
                        er = res_q.pop_front();
                        chk("result_cv", m_cv, er.cv);
                        chk("result_len", m_beat_len, er.len);
                    end
                end
                hold = m_valid && !m_ready;
                pcv  = m_cv;
                plen = m_beat_len;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: s_ready 0 after %0d cycles, required 1", t);
        end
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("wait_m_valid", m_valid, 1);
    endtask

    task automatic send_sample(input logic [DW-1:0] x, input logic [DW-1:0] y, input bit peak);
        wait_ready();
        s_valid = 1'b1;
        s_vqx   = x;
        s_vqy   = y;
        r_peak  = peak;
        start   = ($urandom_range(0, 19) == 0);
        if (x <= LL && y <= LL) begin
            fwd_q.push_back('{x, y});
            cur_len++;
        end else if (exp_drop != '1)
            exp_drop++;
        if (cur_len == MAXB)
            exp_to = 1'b1;
        if (cur_len == MAXB || peak)
            boundary();
        @(negedge clk);
        s_valid = 1'b0;
        r_peak  = 1'b0;
        start   = 1'b0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic peak_only();
        wait_ready();
        r_peak = 1'b1;
        boundary();
        @(negedge clk);
        r_peak = 1'b0;
    endtask

    task automatic run_beat(input int n, input int ending, input bit oor, input logic [DW-1:0] cvy);
        logic [DW-1:0] x, y;
        wait_ready();
        cur_cvy = cvy;
        cv_y    = cvy;
        for (int i = 0; i < n; i++) begin
            x = DW'(oor ? $urandom_range(0, 8) : $urandom_range(0, LL));
            y = DW'(oor ? $urandom_range(0, 8) : $urandom_range(0, LL));
            send_sample(x, y, ending == 0 && i == n - 1);
        end
        if (ending == 1 || (ending == 0 && n == 0))
            peak_only();
    endtask

    task automatic start_session();
        start    = 1'b1;
        calib_ph = 1'b1;
        cur_len  = 0;
        exp_to   = 1'b0;
        exp_cal  = 1'b0;
        qrs_q.push_back(1'b0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_ready(input bit v);
        @(posedge clk);
        #1 m_ready = v;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fwd_q.delete();
        qrs_q.delete();
        res_q.delete();
        cur_len  = 0;
        exp_drop = '0;
        exp_to   = 1'b0;
        exp_cal  = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_drop = '0;
        cur_len  = 0;
        cur_cvy  = '0;
        calib_ph = 1'b1;
        exp_to   = 1'b0;
        exp_cal  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_cv_en", cv_en, 0);
        chk("rst_cv_qrs", cv_qrs, 0);
        chk("rst_cv1_flag", cv1_flag, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_calib_done", calib_done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_m_cv", m_cv, 0);
        chk("rst_m_beat_len", m_beat_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_cv_vqx", cv_vqx, 0);
        chk("rst_cv_vqy", cv_vqy, 0);
        rstn = 1'b0;
        @(negedge clk);
        rdy_auto = 1'b1;
        start_session();
        chk("busy_after_start", busy, 1);
        run_beat(20, 1, 1'b0, 16'h0);
        wait_ready();
        chk("calib_done", calib_done, exp_cal);
        rdy_auto = 1'b0;
        set_ready(1'b0);
        run_beat(20, 1, 1'b0, 16'd3);
        wait_valid();
        repeat (5) begin
            chk("hold_s_ready", s_ready, 0);
            @(negedge clk);
        end
        set_ready(1'b1);
        rdy_auto = 1'b1;
        run_beat(10, 1, 1'b0, DW'($urandom));
        wait_ready();
        send_sample(16'd7, 16'd0, 1'b0);
        send_sample(16'd0, 16'd9, 1'b0);
        send_sample(16'd3, 16'd3, 1'b0);
        chk("drop_cnt", drop_cnt, exp_drop);
        peak_only();
        run_beat(32, 2, 1'b0, DW'($urandom));
        wait_ready();
        chk("timeout", timeout, exp_to);
        repeat (30)
            run_beat($urandom_range(0, 40), $urandom_range(0, 2), 1'b1, DW'($urandom));
        wait_ready();
        chk("rand_drop_cnt", drop_cnt, exp_drop);
        chk("rand_timeout", timeout, exp_to);
        chk("rand_calib_done", calib_done, exp_cal);
        rdy_auto = 1'b0;
        set_ready(1'b0);
        run_beat(16, 0, 1'b0, 16'h55);
        wait_valid();
        if (res_q.size() == 0)
            miss("peak_beat_no_expectation");
        else
            chk("peak_beat_len", m_beat_len, res_q[0].len);
        do_reset();
        chk("abort_busy", busy, 0);
        chk("abort_m_valid", m_valid, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_calib_done", calib_done, 0);
        rdy_auto = 1'b1;
        start_session();
        run_beat(20, 0, 1'b0, DW'($urandom));
        run_beat(18, 0, 1'b0, DW'($urandom));
        wait_ready();
        chk("recal_done", calib_done, exp_cal);
        send_sample(16'd1, 16'd2, 1'b0);
        wait_ready();
        stop    = 1'b1;
        cur_len = 0;
        @(negedge clk);
        stop = 1'b0;
        repeat (4) @(negedge clk);
        chk("stop_busy", busy, 0);
        chk("left_fwd", fwd_q.size(), 0);
        chk("left_qrs", qrs_q.size(), 0);
        chk("left_res", res_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dpsm_beat_ctrl.md
DPSM_BEAT_CTRL -- requirements
Module: dpsm_beat_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of sample coordinates and result.
REQ-002 Parameter L, 6, max quantized coordinate; matrix is (L+1)x(L+1).
REQ-003 Parameter MIN_BEAT, 16, min accepted samples per beat; shorter beats are discarded.
REQ-004 Parameter MAX_BEAT, 1023, max samples per beat before forced boundary.
REQ-005 Port clk  in  1  single clock, all logic on posedge.
REQ-006 Port rstn  in  1  synchronous active-high reset; 1 = reset.
REQ-007 Port start  in  1  pulse; begins a session from IDLE.
REQ-008 Port stop  in  1  pulse; ends the session after any pending result is delivered.
REQ-009 Port s_valid/s_ready  in/out  1/1  sample handshake; transfer when both are 1.
REQ-010 Port s_vqx, s_vqy  in  DATA_WIDTH each  quantized Poincaré coordinates.
REQ-011 Port r_peak  in  1  one-cycle beat-boundary pulse from the QRS detector.
REQ-012 Port cv_en, cv_qrs, cv1_flag  out  1 each  control to the dpsm_cv datapath.
REQ-013 Port cv_vqx, cv_vqy  out  DATA_WIDTH each  coordinates to the datapath.
REQ-014 Port cv_y  in  DATA_WIDTH  datapath ratio output.
REQ-015 Port m_valid/m_ready  out/in  1/1  result handshake.
REQ-016 Port m_cv, m_beat_len  out  DATA_WIDTH each  beat ratio and accepted-sample count.
REQ-017 Port busy, calib_done, timeout  out  1 each  status; drop_cnt  out  DATA_WIDTH  count of out-of-range samples.

Function
REQ-018 States SHALL be IDLE, INIT_CLR, CALIB, CAL_QRS, RUN, RUN_QRS, CAPTURE, HOLD.
REQ-019 IDLE: start -> INIT_CLR; INIT_CLR drives cv_en=1, cv_qrs=1, cv1_flag=0 for one cycle -> CALIB.
REQ-020 s_ready SHALL be 1 only in CALIB and RUN with no boundary pending.
REQ-021 Accepted sample with s_vqx<=L and s_vqy<=L: cv_en=1 and cv_vqx/cv_vqy = sample in the next cycle (one-cycle registered latency); beat length increments.
REQ-022 Out-of-range sample: accepted, not forwarded; drop_cnt increments, saturating at all-ones.
REQ-023 r_peak in CALIB/RUN latches a pending boundary; a sample transferred in the same cycle belongs to the ending beat.
REQ-024 Beat length reaching MAX_BEAT SHALL create a pending boundary and set sticky timeout, cleared on start.
REQ-025 Pending boundary with beat length < MIN_BEAT: issue cv_en=1, cv_qrs=1 and cv1_flag=0 for one cycle, produce no result, and stay in the same phase.
REQ-026 CALIB boundary (length >= MIN_BEAT) -> CAL_QRS: one cycle with cv_en=1, cv_qrs=1, cv1_flag=1; then calib_done=1 -> RUN.
REQ-027 RUN boundary (length >= MIN_BEAT) -> RUN_QRS: one cycle with cv_en=1, cv_qrs=1, cv1_flag=0 -> CAPTURE.
REQ-028 CAPTURE: register cv_y into m_cv and the beat length into m_beat_len; assert m_valid; -> HOLD.
REQ-029 HOLD: m_valid held with m_cv/m_beat_len stable until m_ready=1; then -> RUN, or IDLE if stop was latched.
REQ-030 Beat length SHALL reset to 0 on every issued cv_qrs cycle.
REQ-031 stop in CALIB/RUN with no result pending -> IDLE next cycle; a partial beat is discarded.
REQ-032 start while not in IDLE SHALL be ignored; r_peak in IDLE, INIT_CLR or HOLD SHALL be ignored.
REQ-033 cv_en SHALL be 0 in every cycle not listed above; busy = (state != IDLE).

Reset
REQ-034 On rstn=1 at posedge: state IDLE; s_ready, cv_en, cv_qrs, cv1_flag, m_valid, busy, calib_done and timeout = 0; m_cv, m_beat_len, drop_cnt, cv_vqx and cv_vqy = 0.
REQ-035 Reset mid-session SHALL abort immediately; a held result is lost; the first session after reset SHALL recalibrate.

Structure
REQ-036 The state enum and default L/MIN_BEAT/MAX_BEAT SHALL live in shared package dpsm_pkg.
REQ-037 No sub-module: dpsm_cv SHALL be instantiated beside this block by the parent.

Verification
REQ-038 Reset, start, 20 in-range samples, r_peak -> INIT_CLR pulse, then CAL_QRS with cv1_flag=1, calib_done=1, and no m_valid.
REQ-039 After calibration, 20 samples + r_peak with cv_y=3 -> m_valid, m_cv=3, m_beat_len=20; m_ready held 0 for 5 cycles keeps s_ready=0 and outputs stable.
REQ-040 RUN beat of 10 samples (MIN_BEAT=16) + r_peak -> one cv_qrs cycle, no m_valid, beat length restarts at 0.
REQ-041 Samples (7,0), (0,9) and (3,3) with L=6 -> drop_cnt=2, only (3,3) forwarded on cv_vqx/cv_vqy.
REQ-042 MAX_BEAT=32, 32 samples without r_peak -> forced boundary, timeout=1, m_beat_len=32.
REQ-043 r_peak and s_valid in the same cycle, then rstn pulse during HOLD -> sample counted in the ending beat; after reset, state IDLE and m_valid=0.
